fifo_sync_prog: RTL

//  Parametrised single-clock FIFO; successor of the fixed 8-deep FIFO.

---
 rtl/fifo_shared_pkg.sv | 17 +
 rtl/fifo_mem.sv | 24 ++
 rtl/fifo_sync_prog.sv | 112 +++++++++++
 3 files changed

// File: rtl/fifo_shared_pkg.sv
// Shared constants and helpers for the synchronous FIFO family.
package fifo_shared_pkg;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_FIFO_DEPTH = 8;

  // Pointer increment with wrap at an arbitrary (non power-of-two) depth.
  function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

  // Occupancy counter width: must hold 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// FIFO storage: one synchronous write port, one asynchronous read port, no reset.
module fifo_mem #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 8,
  parameter int AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Write the accepted word; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_sync_prog.sv
// Parametrised single-clock FIFO with programmable thresholds, FWFT option and flush.
module fifo_sync_prog
  import fifo_shared_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int AF_THRESH  = FIFO_DEPTH - 1,
  parameter int AE_THRESH  = 1,
  parameter bit FWFT       = 1'b0
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            flush,
  input  logic                            wr_en,
  input  logic [DATA_WIDTH-1:0]           data_in,
  input  logic                            rd_en,
  output logic [DATA_WIDTH-1:0]           data_out,
  output logic                            wr_ack,
  output logic                            overflow,
  output logic                            underflow,
  output logic                            full,
  output logic                            empty,
  output logic                            almostfull,
  output logic                            almostempty,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] count
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = cnt_width(FIFO_DEPTH);

  if (FIFO_DEPTH < 2) begin : g_bad_depth
    $error("fifo_sync_prog: FIFO_DEPTH must be >= 2");
  end
  if (AF_THRESH < 1 || AF_THRESH > FIFO_DEPTH - 1) begin : g_bad_af
    $error("fifo_sync_prog: AF_THRESH must be in 1..FIFO_DEPTH-1");
  end
  if (AE_THRESH < 1 || AE_THRESH > FIFO_DEPTH - 1) begin : g_bad_ae
    $error("fifo_sync_prog: AE_THRESH must be in 1..FIFO_DEPTH-1");
  end

  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  wr_acc, rd_acc;

  // Flags are pure decode of the occupancy count.
  assign full        = (count == CW'(FIFO_DEPTH));
  assign empty       = (count == '0);
  assign almostfull  = (count >= CW'(AF_THRESH)) && !full;
  assign almostempty = (count <= CW'(AE_THRESH)) && !empty;

  // Flush overrides both requests; acceptance uses pre-edge flags.
  assign wr_acc = wr_en && !full  && !flush;
  assign rd_acc = rd_en && !empty && !flush;

  fifo_mem #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH), .AW(PW)) u_mem (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wr_ptr),
    .wdata (data_in),
    .raddr (rd_ptr),
    .rdata (rdata)
  );

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_acc) wr_ptr <= PW'(ptr_inc(32'(wr_ptr), FIFO_DEPTH));
      if (rd_acc) rd_ptr <= PW'(ptr_inc(32'(rd_ptr), FIFO_DEPTH));
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // One-cycle handshake pulses reporting last cycle's request outcome.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || flush) begin
      wr_ack    <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      wr_ack    <= wr_acc;
      overflow  <= wr_en && full;
      underflow <= rd_en && empty;
    end
  end

  if (FWFT) begin : g_fwft
    // Head word is exposed directly; zero while nothing is stored.
    assign data_out = empty ? '0 : rdata;
  end else begin : g_reg
    logic [DATA_WIDTH-1:0] dout_q;
    // Registered read: capture the head on an accepted pop, otherwise hold.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      dout_q <= '0;
      else if (flush)  dout_q <= '0;
      else if (rd_acc) dout_q <= rdata;
    end
    assign data_out = dout_q;
  end

endmodule
